// File: rtl/ov5640_init_sequencer.sv
// OV5640 register-table init sequencer: walks a ROM of {reg, data} words
// and issues SCCB writes with power-up/soft-reset waits and per-entry retries.
module ov5640_init_sequencer #(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          TABLE_LEN      = 91,
    parameter logic [19:0] POWERUP_CYCLES = 20'd50000,
    parameter logic [19:0] SWRESET_CYCLES = 20'd250000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err
);

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        LATCH,
        WRITE,
        RETRY_GAP,
        SWRST,
        DONE,
        ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(TABLE_LEN - 1);
    localparam logic [7:0] RMAX = 8'(MAX_RETRY);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] idx, idx_nx;
    logic [7:0]            retry, retry_nx;
    logic [19:0]           cnt, cnt_nx;
    logic [15:0]           reg_addr, reg_addr_nx;
    logic [7:0]            data, data_nx;
    logic                  done_q, done_nx;
    logic                  err_q, err_nx;
    logic                  adv;
    logic                  pw_end, sw_end;
    logic                  is_swrst;
    logic [7:0]            retry_inc;

    // A zero wait still spends one cycle in the wait state.
    assign pw_end = ({1'b0, cnt} + 21'd1) >= {1'b0, POWERUP_CYCLES};
    assign sw_end = ({1'b0, cnt} + 21'd1) >= {1'b0, SWRESET_CYCLES};
    assign is_swrst  = (reg_addr == 16'h3008) && data[7];
    assign retry_inc = retry + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            retry    <= '0;
            cnt      <= '0;
            reg_addr <= '0;
            data     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            retry    <= retry_nx;
            cnt      <= cnt_nx;
            reg_addr <= reg_addr_nx;
            data     <= data_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        retry_nx    = retry;
        cnt_nx      = '0;
        reg_addr_nx = reg_addr;
        data_nx     = data;
        done_nx     = done_q;
        err_nx      = err_q;
        adv         = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nx = PWRUP;
                    idx_nx   = '0;
                    retry_nx = '0;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            PWRUP: begin
                if (pw_end) state_nx = FETCH;
                else        cnt_nx   = cnt + 20'd1;
            end
            FETCH: state_nx = LATCH;
            LATCH: begin
                reg_addr_nx = rom_q[23:8];
                data_nx     = rom_q[7:0];
                state_nx    = WRITE;
            end
            WRITE: begin
                // A NACK outranks a simultaneous ACK.
                if (wr_err) begin
                    retry_nx = retry_inc;
                    if (retry_inc == RMAX) begin
                        state_nx = ERROR;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = RETRY_GAP;
                    end
                end else if (wr_done) begin
                    if (is_swrst) state_nx = SWRST;
                    else          adv      = 1'b1;
                end
            end
            RETRY_GAP: state_nx = WRITE;
            SWRST: begin
                if (sw_end) adv    = 1'b1;
                else        cnt_nx = cnt + 20'd1;
            end
            default: state_nx = IDLE;
        endcase
        if (adv) begin
            if (idx == LAST) begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end else begin
                idx_nx   = idx + ADDR_WIDTH'(1);
                retry_nx = '0;
                state_nx = FETCH;
            end
        end
    end

    assign rom_addr    = idx;
    assign wr_req      = (state == WRITE);
    assign wr_reg_addr = reg_addr;
    assign wr_data     = data;
    assign busy        = !(state == IDLE || state == DONE
                           || state == ERROR);
    assign init_done   = done_q;
    assign init_err    = err_q;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Directed bench for ov5640_init_sequencer: normal run, NACK retry,
// retry exhaustion, simultaneous ACK/NACK and mid-write reset.
module tb_ov5640_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic        wr_req;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_err;
    logic        busy;
    logic        init_done;
    logic        init_err;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] rom [4];

    localparam logic [23:0] W0 = 24'h3008_82;
    localparam logic [23:0] W1 = 24'h3103_03;
    localparam logic [23:0] W2 = 24'h3017_ff;
    localparam logic [23:0] W3 = 24'h3018_ff;

    localparam int R_ACK  = 0;
    localparam int R_NACK = 1;
    localparam int R_BOTH = 2;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

    ov5640_init_sequencer #(
        .ADDR_WIDTH    (8),
        .TABLE_LEN     (4),
        .POWERUP_CYCLES(20'd10),
        .SWRESET_CYCLES(20'd5),
        .MAX_RETRY     (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .wr_req     (wr_req),
        .wr_reg_addr(wr_reg_addr),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Waits for wr_req counting low cycles, holds 3 cycles, responds.
    task automatic do_write(input string tag,
                            input logic [23:0] word,
                            input int resp,
                            input int exp_low,
                            input bit poke);
        int low;
        low = 0;
        while (!wr_req && low < 300) begin
            low++;
            @(negedge clk);
        end
        chk({tag, " low"}, low, exp_low);
        if (!wr_req) return;
        chk({tag, " word"}, {wr_reg_addr, wr_data}, word);
        @(negedge clk);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " hold"}, {wr_req, wr_reg_addr, wr_data},
            {1'b1, word});
        @(negedge clk);
        wr_done = (resp == R_ACK) || (resp == R_BOTH);
        wr_err  = (resp == R_NACK) || (resp == R_BOTH);
        @(negedge clk);
        wr_done = 1'b0;
        wr_err  = 1'b0;
        chk({tag, " drop"}, wr_req, 1'b0);
    endtask

    initial begin
        int low;
        rom[0] = W0;
        rom[1] = W1;
        rom[2] = W2;
        rom[3] = W3;
        rst_n   = 1'b0;
        start   = 1'b0;
        wr_done = 1'b0;
        wr_err  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst out", {busy, init_done, init_err, wr_req}, 4'b0);
        chk("rst bus", {rom_addr, wr_reg_addr, wr_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", busy, 1'b0);

        // Normal run
        pulse_start();
        chk("run busy", busy, 1'b1);
        do_write("n0", W0, R_ACK, 12, 1'b0);
        do_write("n1", W1, R_ACK, 7, 1'b0);
        do_write("n2", W2, R_ACK, 2, 1'b0);
        do_write("n3", W3, R_ACK, 2, 1'b0);
        chk("n end", {init_done, busy, init_err}, 3'b100);

        // NACK recovery with a start poke during a write
        pulse_start();
        chk("r clr", init_done, 1'b0);
        do_write("r0", W0, R_ACK, 12, 1'b0);
        do_write("r1a", W1, R_NACK, 7, 1'b1);
        do_write("r1b", W1, R_NACK, 1, 1'b0);
        do_write("r1c", W1, R_ACK, 1, 1'b0);
        do_write("r2", W2, R_ACK, 2, 1'b0);
        do_write("r3", W3, R_ACK, 2, 1'b0);
        chk("r end", {init_done, busy, init_err}, 3'b100);

        // Retry exhaustion
        pulse_start();
        do_write("x0", W0, R_ACK, 12, 1'b0);
        do_write("x1", W1, R_ACK, 7, 1'b0);
        do_write("x2a", W2, R_NACK, 2, 1'b0);
        do_write("x2b", W2, R_NACK, 1, 1'b0);
        do_write("x2c", W2, R_NACK, 1, 1'b0);
        chk("x end", {init_err, wr_req, busy, init_done}, 4'b1000);
        repeat (3) @(negedge clk);
        chk("x hold", {init_err, busy}, 2'b10);

        // Restart from ERROR, then simultaneous ACK/NACK on entry 3
        pulse_start();
        chk("s clr", {init_err, busy, init_done}, 3'b010);
        do_write("s0", W0, R_ACK, 12, 1'b0);
        do_write("s1", W1, R_ACK, 7, 1'b0);
        do_write("s2", W2, R_ACK, 2, 1'b0);
        do_write("s3a", W3, R_BOTH, 2, 1'b0);
        do_write("s3b", W3, R_BOTH, 1, 1'b0);
        do_write("s3c", W3, R_ACK, 1, 1'b0);
        chk("s end", {init_done, busy, init_err}, 3'b100);

        // Reset in the middle of the entry-2 write
        pulse_start();
        do_write("m0", W0, R_ACK, 12, 1'b0);
        do_write("m1", W1, R_ACK, 7, 1'b0);
        low = 0;
        while (!wr_req && low < 300) begin
            low++;
            @(negedge clk);
        end
        chk("m2 low", low, 2);
        rst_n   = 1'b0;
        wr_done = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        chk("m rst out", {busy, init_done, init_err, wr_req}, 4'b0);
        chk("m rst bus", {rom_addr, wr_reg_addr, wr_data}, 32'h0);
        rst_n   = 1'b1;
        wr_done = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        chk("m idle", {busy, wr_req}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ov5640_init_sequencer.md
OV5640_INIT_SEQUENCER -- requirements
Module: ov5640_init_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of the table address bus.
REQ-002 Parameter TABLE_LEN, default 91: number of table entries to write, indices 0..TABLE_LEN-1.
REQ-003 Parameter POWERUP_CYCLES, default 20'd50000: wait, in clk cycles, before the first write.
REQ-004 Parameter SWRESET_CYCLES, default 20'd250000: wait after a soft-reset write (register 0x3008 with data bit 7 set).
REQ-005 Parameter MAX_RETRY, default 3: number of failed attempts per entry that triggers the error state.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 start  input  1  single-cycle pulse that launches the init sequence.
REQ-009 rom_addr  output  ADDR_WIDTH  table index; the table returns data one cycle after the address.
REQ-010 rom_q  input  24  table word: {register address[23:8], data[7:0]}.
REQ-011 wr_req  output  1  SCCB write request, level-held.
REQ-012 wr_reg_addr  output  16  register address for the current write.
REQ-013 wr_data  output  8  register data for the current write.
REQ-014 wr_done  input  1  pulse from the SCCB master: the write completed with ACK.
REQ-015 wr_err  input  1  pulse from the SCCB master: the write completed with NACK.
REQ-016 busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-017 init_done  output  1  high, and held, after all entries are written.
REQ-018 init_err  output  1  high, and held, after a retry exhaustion.

Function
REQ-019 FSM states: IDLE, PWRUP, FETCH, LATCH, WRITE, RETRY_GAP, SWRST, DONE, ERROR.
REQ-020 IDLE/DONE/ERROR with start=1: idx<=0, retry<=0, init_done<=0, init_err<=0, delay counter<=0; next state PWRUP.
REQ-021 start is ignored while busy=1.
REQ-022 PWRUP: count exactly POWERUP_CYCLES cycles, then go to FETCH.
REQ-023 FETCH: rom_addr=idx for one cycle; next state LATCH.
REQ-024 LATCH: register wr_reg_addr<=rom_q[23:8] and wr_data<=rom_q[7:0]; next state WRITE.
REQ-025 WRITE: wr_req=1 with wr_reg_addr/wr_data stable until wr_done or wr_err is sampled high.
REQ-026 wr_req deasserts on the cycle after the terminating pulse is sampled.
REQ-027 If wr_done and wr_err are high in the same cycle, wr_err wins.
REQ-028 On wr_err: retry<=retry+1; if retry+1==MAX_RETRY go to ERROR, else go to RETRY_GAP.
REQ-029 RETRY_GAP: wr_req=0 for exactly one cycle, then return to WRITE with the same address and data.
REQ-030 On wr_done, if wr_reg_addr==16'h3008 and wr_data[7]=1: go to SWRST and count SWRESET_CYCLES before advancing.
REQ-031 Advance rule: if idx==TABLE_LEN-1 go to DONE; else idx<=idx+1, retry<=0, go to FETCH.
REQ-032 A soft-reset entry in the last position goes to DONE after its SWRST wait.
REQ-033 wr_done or wr_err asserted outside WRITE is ignored.
REQ-034 The delay counter is 20 bits, clears on every state entry, and does not wrap.
REQ-035 A POWERUP_CYCLES or SWRESET_CYCLES value of 0 gives a one-cycle pass-through.

Reset
REQ-036 rst_n=0 at a clock edge forces, on that edge, from any state including mid-write: state IDLE, idx=0, retry=0, rom_addr=0, wr_req=0, wr_reg_addr=0, wr_data=0, busy=0, init_done=0, init_err=0, delay counter=0.
REQ-037 Reset takes priority over start and over all handshake inputs.

Verification (TABLE_LEN=4, POWERUP_CYCLES=10, SWRESET_CYCLES=5, MAX_RETRY=3; table = 3008_82, 3103_03, 3017_ff, 3018_ff)
REQ-038 Normal run: start pulse, SCCB model acks each request after 3 cycles -> four writes issued in table order; the first wr_req rises at least 10 cycles after start; a 5-cycle gap follows the 3008_82 write; init_done=1 and busy=0 after the fourth ack.
REQ-039 NACK recovery: wr_err twice on entry 1, then wr_done -> 3103_03 issued three times, with wr_req low for exactly one cycle between attempts; sequence completes with init_err=0.
REQ-040 Retry exhaustion: wr_err three times on entry 2 -> init_err=1, wr_req=0, busy=0, init_done=0; a later start reruns from index 0 with init_err cleared.
REQ-041 Simultaneous wr_done and wr_err on entry 3 -> treated as an error (retry count incremented, same entry reissued).
REQ-042 Reset mid-WRITE on entry 2 -> all outputs at REQ-036 values on the next cycle; start pulses during busy=1 have no effect.
